// File: rtl/imem_loadable.sv
// Instruction memory with a sequential load port and a registered fetch output (1-cycle latency).
// Fetch is dropped during LOAD; stall holds q/q_valid/oob; fetches at or beyond the loaded length return NOP with oob.
module imem_loadable #(
  parameter int              N      = 32,
  parameter int              ADDR_W = 10,
  parameter logic [N-1:0]    NOP    = 32'h8b1f03ff
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              i_load_start,
  input  logic              i_load_valid,
  input  logic [N-1:0]      i_load_data,
  input  logic              i_load_done,
  output logic              o_load_ready,
  output logic              o_busy,
  output logic [ADDR_W:0]   o_load_count,
  input  logic              i_fetch_req,
  input  logic [ADDR_W-1:0] i_addr,
  input  logic              i_stall,
  output logic [N-1:0]      o_q,
  output logic              o_q_valid,
  output logic              o_oob
);

  localparam int DEPTH = 2 ** ADDR_W;
  localparam logic [ADDR_W:0] FULL = {1'b1, {ADDR_W{1'b0}}};
  localparam logic [ADDR_W:0] LAST = {1'b0, {ADDR_W{1'b1}}};
  localparam logic [ADDR_W:0] ONE  = {{ADDR_W{1'b0}}, 1'b1};

  typedef enum logic {ST_RUN, ST_LOAD} state_t;

  state_t            r_state, w_state_nxt;
  logic [ADDR_W:0]   r_wr_ptr, w_wr_ptr_nxt;
  logic [ADDR_W:0]   r_limit, w_limit_nxt;
  logic [N-1:0]      r_q, w_q_nxt;
  logic              r_q_valid, w_q_valid_nxt;
  logic              r_oob, w_oob_nxt;
  logic              w_mem_we;
  logic [N-1:0]      w_rd_dat;

  // Contents survive reset; only the elaboration fill sets them to NOP.
  logic [N-1:0] r_mem [DEPTH] = '{default: NOP};

  assign w_rd_dat = r_mem[i_addr];

  always_comb begin
    w_state_nxt   = r_state;
    w_wr_ptr_nxt  = r_wr_ptr;
    w_limit_nxt   = r_limit;
    w_q_nxt       = r_q;
    w_q_valid_nxt = r_q_valid;
    w_oob_nxt     = r_oob;
    w_mem_we      = 1'b0;
    case (r_state)
      ST_RUN: begin
        if (i_load_start) begin
          w_state_nxt   = ST_LOAD;
          w_wr_ptr_nxt  = '0;
          w_q_nxt       = NOP;
          w_q_valid_nxt = 1'b0;
          w_oob_nxt     = 1'b0;
        end else if (i_stall) begin
          w_q_nxt       = r_q;
        end else if (i_fetch_req) begin
          w_q_valid_nxt = 1'b1;
          if ({1'b0, i_addr} < r_limit) begin
            w_q_nxt   = w_rd_dat;
            w_oob_nxt = 1'b0;
          end else begin
            w_q_nxt   = NOP;
            w_oob_nxt = 1'b1;
          end
        end else begin
          w_q_nxt       = NOP;
          w_q_valid_nxt = 1'b0;
          w_oob_nxt     = 1'b0;
        end
      end
      ST_LOAD: begin
        w_q_nxt       = NOP;
        w_q_valid_nxt = 1'b0;
        w_oob_nxt     = 1'b0;
        if (i_load_start) begin
          // Restart: the same-cycle word is discarded.
          w_wr_ptr_nxt = '0;
        end else begin
          if (i_load_valid) begin
            w_mem_we     = 1'b1;
            w_wr_ptr_nxt = r_wr_ptr + ONE;
          end
          if (i_load_valid && (r_wr_ptr == LAST)) begin
            w_state_nxt = ST_RUN;
            w_limit_nxt = FULL;
          end else if (i_load_done) begin
            w_state_nxt = ST_RUN;
            w_limit_nxt = r_wr_ptr + {{ADDR_W{1'b0}}, i_load_valid};
          end
        end
      end
      default: w_state_nxt = ST_RUN;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state   <= ST_RUN;
      r_wr_ptr  <= '0;
      r_limit   <= FULL;
      r_q       <= NOP;
      r_q_valid <= 1'b0;
      r_oob     <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_wr_ptr  <= w_wr_ptr_nxt;
      r_limit   <= w_limit_nxt;
      r_q       <= w_q_nxt;
      r_q_valid <= w_q_valid_nxt;
      r_oob     <= w_oob_nxt;
    end
  end

  always_ff @(posedge i_clk) begin
    if (w_mem_we && !i_reset) begin
      r_mem[r_wr_ptr[ADDR_W-1:0]] <= i_load_data;
    end
  end

  assign o_load_ready = (r_state == ST_LOAD);
  assign o_busy       = (r_state == ST_LOAD);
  assign o_load_count = r_limit;
  assign o_q          = r_q;
  assign o_q_valid    = r_q_valid;
  assign o_oob        = r_oob;

endmodule

// File: tb/tb_imem_loadable.sv
// Bench for imem_loadable: directed scenarios plus randomized load/fetch traffic against an array model.
module tb_imem_loadable;
  localparam int          DEPTH = 1024;
  localparam logic [31:0] NOP   = 32'h8b1f03ff;

  logic        clk = 1'b0;
  logic        reset, load_start, load_valid, load_done, fetch_req, stall;
  logic [31:0] load_data;
  logic [9:0]  addr;
  logic        load_ready, busy, q_valid, oob;
  logic [10:0] load_count;
  logic [31:0] q;

  int checks = 0;
  int errors = 0;

  logic [31:0] m_mem [DEPTH];
  int          m_limit;
  logic [31:0] load_q[$];
  bit          gaps;

  imem_loadable dut (
    .i_clk(clk), .i_reset(reset), .i_load_start(load_start), .i_load_valid(load_valid),
    .i_load_data(load_data), .i_load_done(load_done), .o_load_ready(load_ready), .o_busy(busy),
    .o_load_count(load_count), .i_fetch_req(fetch_req), .i_addr(addr), .i_stall(stall),
    .o_q(q), .o_q_valid(q_valid), .o_oob(oob)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "timeout");
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs;
    load_start = 0; load_valid = 0; load_done = 0; load_data = '0;
    fetch_req = 0; stall = 0; addr = '0;
  endtask

  // Streams load_q into the memory, optionally with load_done on the last word; updates the model.
  task automatic do_load(input bit with_done);
    int n;
    n = load_q.size();
    idle_inputs();
    load_start = 1; tick(); load_start = 0;
    for (int i = 0; i < n; i++) begin
      while (gaps && ($urandom_range(0, 3) == 0)) begin
        load_valid = 0; tick();
      end
      load_valid = 1;
      load_data  = load_q[i];
      load_done  = with_done && (i == n - 1);
      tick();
      m_mem[i] = load_q[i];
    end
    if (n == 0 && with_done) begin
      load_done = 1; tick();
    end
    idle_inputs();
    if (n == DEPTH) m_limit = DEPTH;
    else if (with_done) m_limit = n;
  endtask

  task automatic test_reset;
    idle_inputs();
    reset = 1; tick(); tick();
    if (q !== NOP)          begin errors++; $display("FAIL reset_q got %h want %h", q, NOP); end
    if (q_valid !== 1'b0)   begin errors++; $display("FAIL reset_q_valid got %b want 0", q_valid); end
    if (oob !== 1'b0)       begin errors++; $display("FAIL reset_oob got %b want 0", oob); end
    if ({busy, load_ready} !== 2'b00) begin errors++; $display("FAIL reset_busy got %b%b want 00", busy, load_ready); end
    if (load_count !== 11'd1024) begin errors++; $display("FAIL reset_count got %0d want 1024", load_count); end
    checks += 5;
    reset = 0;
    fetch_req = 1; addr = 10'd5; tick(); fetch_req = 0;
    if ({q, q_valid, oob} !== {NOP, 1'b1, 1'b0}) begin
      errors++; $display("FAIL fetch_after_reset got q=%h v=%b oob=%b want %h 1 0", q, q_valid, oob, NOP);
    end
    checks++;
  endtask

  task automatic test_load_basic;
    logic [31:0] exp;
    load_q = '{32'h91000631, 32'hf8094011, 32'hd1000652};
    do_load(1);
    if ({busy, load_ready} !== 2'b00) begin errors++; $display("FAIL load3_busy got %b%b want 00", busy, load_ready); end
    if (load_count !== 11'd3) begin errors++; $display("FAIL load3_count got %0d want 3", load_count); end
    checks += 2;
    for (int a = 0; a < 3; a++) begin
      fetch_req = 1; addr = 10'(a); tick();
      exp = load_q[a];
      if ({q, q_valid, oob} !== {exp, 1'b1, 1'b0}) begin
        errors++; $display("FAIL load3_fetch%0d got q=%h v=%b oob=%b want %h 1 0", a, q, q_valid, oob, exp);
      end
      checks++;
    end
    idle_inputs();
  endtask

  task automatic test_oob_stall;
    fetch_req = 1; addr = 10'd3; tick();
    if ({q, q_valid, oob} !== {NOP, 1'b1, 1'b1}) begin
      errors++; $display("FAIL oob_fetch3 got q=%h v=%b oob=%b want %h 1 1", q, q_valid, oob, NOP);
    end
    checks++;
    addr = 10'd2; stall = 1;
    for (int c = 0; c < 2; c++) begin
      tick();
      if ({q, q_valid, oob} !== {NOP, 1'b1, 1'b1}) begin
        errors++; $display("FAIL stall_hold%0d got q=%h v=%b oob=%b want %h 1 1", c, q, q_valid, oob, NOP);
      end
      checks++;
    end
    stall = 0; tick();
    if ({q, q_valid, oob} !== {32'hd1000652, 1'b1, 1'b0}) begin
      errors++; $display("FAIL stall_release got q=%h v=%b oob=%b want d1000652 1 0", q, q_valid, oob);
    end
    checks++;
    idle_inputs();
  endtask

  task automatic test_full_fill;
    load_q.delete();
    for (int i = 0; i < DEPTH; i++) load_q.push_back(32'(i));
    gaps = 1;
    do_load(0);
    gaps = 0;
    if (busy !== 1'b0) begin errors++; $display("FAIL full_busy got %b want 0", busy); end
    if (load_count !== 11'd1024) begin errors++; $display("FAIL full_count got %0d want 1024", load_count); end
    checks += 2;
    fetch_req = 1; addr = 10'd1023; tick();
    if ({q, q_valid, oob} !== {32'd1023, 1'b1, 1'b0}) begin
      errors++; $display("FAIL full_fetch1023 got q=%h v=%b oob=%b want 3ff 1 0", q, q_valid, oob);
    end
    addr = 10'd0; tick();
    if ({q, q_valid, oob} !== {32'd0, 1'b1, 1'b0}) begin
      errors++; $display("FAIL full_fetch0 got q=%h v=%b oob=%b want 0 1 0", q, q_valid, oob);
    end
    checks += 2;
    idle_inputs();
  endtask

  task automatic test_abort_restart;
    idle_inputs();
    load_start = 1; tick(); load_start = 0;
    for (int i = 0; i < 4; i++) begin
      load_valid = 1; load_data = 32'ha0 + 32'(i); tick(); m_mem[i] = load_data;
    end
    load_start = 1; load_valid = 1; load_data = 32'hdeadbeef; tick();
    load_start = 0;
    if (busy !== 1'b1) begin errors++; $display("FAIL abort_busy got %b want 1", busy); end
    checks++;
    load_data = 32'h11; tick(); m_mem[0] = 32'h11;
    load_data = 32'h22; load_done = 1; tick(); m_mem[1] = 32'h22; m_limit = 2;
    idle_inputs();
    if ({busy, load_count} !== {1'b0, 11'd2}) begin
      errors++; $display("FAIL abort_count got busy=%b count=%0d want 0 2", busy, load_count);
    end
    checks++;
    fetch_req = 1;
    for (int a = 0; a < 3; a++) begin
      addr = 10'(a); tick();
      if ({q, oob} !== {(a < m_limit) ? m_mem[a] : NOP, a >= m_limit}) begin
        errors++; $display("FAIL abort_fetch%0d got q=%h oob=%b", a, q, oob);
      end
      checks++;
    end
    idle_inputs();
    // Reset during a load: partial words stay readable, limit returns to full depth.
    load_start = 1; tick(); load_start = 0;
    for (int i = 0; i < 4; i++) begin
      load_valid = 1; load_data = 32'hb0 + 32'(i); tick(); m_mem[i] = load_data;
    end
    idle_inputs();
    reset = 1; tick(); reset = 0; m_limit = DEPTH;
    if ({busy, load_count} !== {1'b0, 11'd1024}) begin
      errors++; $display("FAIL midreset got busy=%b count=%0d want 0 1024", busy, load_count);
    end
    checks++;
    fetch_req = 1;
    for (int a = 0; a < 5; a++) begin
      addr = 10'(a); tick();
      if ({q, q_valid, oob} !== {m_mem[a], 1'b1, 1'b0}) begin
        errors++; $display("FAIL midreset_fetch%0d got q=%h v=%b oob=%b want %h 1 0", a, q, q_valid, oob, m_mem[a]);
      end
      checks++;
    end
    idle_inputs();
  endtask

  task automatic test_start_fetch;
    idle_inputs();
    load_start = 1; fetch_req = 1; addr = 10'd0; tick(); load_start = 0;
    if ({q, q_valid, busy} !== {NOP, 1'b0, 1'b1}) begin
      errors++; $display("FAIL start_fetch got q=%h v=%b busy=%b want %h 0 1", q, q_valid, busy, NOP);
    end
    tick();
    if (q_valid !== 1'b0) begin errors++; $display("FAIL load_ignores_fetch got v=%b want 0", q_valid); end
    checks += 2;
    fetch_req = 0; load_done = 1; tick(); load_done = 0; m_limit = 0;
    if (load_count !== 11'd0) begin errors++; $display("FAIL empty_count got %0d want 0", load_count); end
    checks++;
    fetch_req = 1; addr = 10'd0; tick();
    if ({q, q_valid, oob} !== {NOP, 1'b1, 1'b1}) begin
      errors++; $display("FAIL empty_fetch got q=%h v=%b oob=%b want %h 1 1", q, q_valid, oob, NOP);
    end
    fetch_req = 0; stall = 0; tick();
    if ({q, q_valid, oob} !== {NOP, 1'b0, 1'b0}) begin
      errors++; $display("FAIL idle got q=%h v=%b oob=%b want %h 0 0", q, q_valid, oob, NOP);
    end
    checks += 2;
    idle_inputs();
  endtask

  task automatic test_random;
    logic [31:0] e_q;
    logic        e_v, e_oob;
    int          n, a;
    e_q = NOP; e_v = 0; e_oob = 0;
    gaps = 1;
    for (int it = 0; it < 400; it++) begin
      if ($urandom_range(0, 15) == 0) begin
        load_q.delete();
        n = $urandom_range(0, 20);
        for (int i = 0; i < n; i++) load_q.push_back($urandom);
        do_load(1);
        if ({busy, load_count} !== {1'b0, 11'(m_limit)}) begin
          errors++; $display("FAIL rnd_load%0d got busy=%b count=%0d want 0 %0d", it, busy, load_count, m_limit);
        end
        checks++;
        e_q = NOP; e_v = 0; e_oob = 0;
      end else begin
        fetch_req = ($urandom_range(0, 3) != 0);
        stall     = ($urandom_range(0, 4) == 0);
        a         = $urandom_range(0, 31);
        addr      = 10'(a);
        tick();
        if (!stall) begin
          if (fetch_req) begin
            e_v   = 1;
            e_oob = (a >= m_limit);
            e_q   = e_oob ? NOP : m_mem[a];
          end else begin
            e_q = NOP; e_v = 0; e_oob = 0;
          end
        end
        if ({q, q_valid, oob} !== {e_q, e_v, e_oob}) begin
          errors++; $display("FAIL rnd_fetch%0d addr=%0d got q=%h v=%b oob=%b want %h %b %b",
                             it, a, q, q_valid, oob, e_q, e_v, e_oob);
        end
        checks++;
      end
    end
    gaps = 0;
    idle_inputs();
  endtask

  initial begin
    for (int i = 0; i < DEPTH; i++) m_mem[i] = NOP;
    m_limit = DEPTH;
    gaps = 0;
    reset = 1;
    idle_inputs();
    test_reset();
    test_load_basic();
    test_oob_stall();
    test_full_fill();
    test_abort_restart();
    test_start_fetch();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/imem_loadable.md
Name: imem_loadable

Overview:
- Parametrised successor to the fixed-content instruction ROM of the LEGv8 pipelined core.
- Synchronous-read instruction memory with a sequential load port, so programs are streamed in by a testbench or boot loader instead of being compiled into the array.
- Registered fetch output with stall hold and NOP bubbles; fetches beyond the loaded program length return NOP and flag out-of-bounds.
- Sits between the PC / fetch stage and IF/ID.

Parameters:
N, 32, instruction width in bits
ADDR_W, 10, word-address width; DEPTH = 2**ADDR_W
NOP, 32'h8b1f03ff, bubble / fill word (ADD XZR,XZR,XZR)

Ports:
clk  in  1  clock, all state updates on rising edge
reset  in  1  synchronous, active-high
load_start  in  1  pulse: enter LOAD, clear write pointer
load_valid  in  1  load_data is valid this cycle
load_data  in  N  instruction word to write
load_done  in  1  pulse: end of program, return to RUN
load_ready  out  1  1 while in LOAD
busy  out  1  1 while in LOAD
load_count  out  ADDR_W+1  words written by last completed load
fetch_req  in  1  fetch request at addr
addr  in  ADDR_W  word address (PC[ADDR_W+1:2] supplied by fetch stage)
stall  in  1  hold current output
q  out  N  fetched instruction, registered
q_valid  out  1  q holds a real fetch result
oob  out  1  q came from an address >= limit

Behaviour:
- Array: DEPTH x N. Initialised to NOP at elaboration. Never cleared by reset; contents persist across reset.
- FSM states: RUN, LOAD.
- Reset outputs and state:
  - state=RUN, q=NOP, q_valid=0, oob=0, load_ready=0, busy=0
  - wr_ptr=0, load_count=DEPTH, limit=DEPTH
- RUN priority, highest first:
  - load_start: go to LOAD, wr_ptr<=0, q<=NOP, q_valid<=0, oob<=0. A same-cycle fetch is dropped.
  - stall=1: q, q_valid and oob hold.
  - fetch_req=1:
    - addr < limit: q<=mem[addr], oob<=0
    - addr >= limit: q<=NOP, oob<=1
    - q_valid<=1 in both cases. Latency is exactly 1 cycle (request at edge k, data valid after edge k+1).
  - else: q<=NOP, q_valid<=0, oob<=0.
- LOAD:
  - load_ready=1, busy=1. q=NOP, q_valid=0, oob=0 throughout. fetch_req and stall are ignored.
  - load_valid=1: mem[wr_ptr]<=load_data, wr_ptr<=wr_ptr+1.
  - load_done=1: go to RUN; load_count and limit <= wr_ptr plus 1 if load_valid is asserted that cycle. The same-cycle word is written and counted.
  - Full: a write at wr_ptr=DEPTH-1 auto-returns to RUN with load_count=limit=DEPTH; no wrap-around. load_done that cycle is redundant.
  - load_start in LOAD aborts and restarts: wr_ptr<=0. A same-cycle load_valid word is discarded. Words already written remain in the array.
  - load_done with zero words written: limit=0, so every fetch returns NOP with oob=1.
- Reset mid-load: state=RUN, limit=DEPTH, load_count=DEPTH. Partially written words stay in the array.
- Read/write conflicts are impossible because fetch is disabled in LOAD.
- load_count and limit change only on LOAD exit or reset.

Test Plan:
1. Reset, then fetch_req=1 addr=5 -> next cycle q=NOP (elaboration fill), q_valid=1, oob=0, load_count=1024.
2. load_start; stream 32'h91000631, 32'hf8094011, 32'hd1000652 with load_valid; load_done on the third word -> busy falls, load_count=3. Fetches of addr 0,1,2 on consecutive cycles give q=91000631, f8094011, d1000652, each one cycle later, q_valid=1.
3. After test 2, fetch addr=3 -> q=NOP, oob=1, q_valid=1. Fetch addr=2 with stall=1 on the following cycle -> q holds NOP, oob=1 until stall drops.
4. Fill all 1024 words (word i = i) without load_done -> auto-return to RUN after the 1024th write, load_count=1024. Fetch addr=1023 -> q=1023, oob=0.
5. Mid-load (after 4 words) assert load_start with load_valid=1 and data=DEADBEEF -> DEADBEEF is not written, wr_ptr restarts at 0. Load 2 words then load_done -> load_count=2. Also: reset after 4 words of a load -> busy=0, load_count=1024, the 4 words are readable.
6. In RUN, load_start and fetch_req on the same cycle -> q_valid=0, busy=1, no fetch result appears. Separately: fetch_req=0, stall=0 -> q=NOP, q_valid=0 next cycle.
